// File: rtl/led_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl_if
//
// Purpose:
//   Groups the pattern-control signals between the ARM GPIO / divider side
//   and the LED pattern stage. The system clock and reset stay as plain
//   ports on the module.
//
// Signal summary:
//   tick         one-cycle step strobe from the upstream divider
//   mode_async   2-bit pattern select from ARM GPIO (asynchronous to sclk)
//   led          registered LED drive, NUM_LED bits
//   mode_cur     registered currently-applied mode (also the FSM state)
//   dbg_phase    blink phase register
//   dbg_chase    chase vector register
//   dbg_duty     breathe duty register
//   dbg_dir_down breathe direction (1 = counting down)
//   dbg_pwm_cnt  breathe PWM counter
//
// Handshake semantics:
//   There is no valid/ready pair on this block. tick is a pure strobe: every
//   sclk cycle in which tick is high is one pattern step, and the block never
//   stalls the producer. mode_async is a level that may change at any time.
//
// Modports:
//   master  drives tick / mode_async, observes everything else
//   slave   the pattern stage itself
// ---------------------------------------------------------------------------
interface led_pattern_ctrl_if #(
    parameter int NUM_LED  = 2,
    parameter int PWM_BITS = 8
);
    logic                tick;
    logic [1:0]          mode_async;
    logic [NUM_LED-1:0]  led;
    logic [1:0]          mode_cur;

    logic                dbg_phase;
    logic [NUM_LED-1:0]  dbg_chase;
    logic [PWM_BITS-1:0] dbg_duty;
    logic                dbg_dir_down;
    logic [PWM_BITS-1:0] dbg_pwm_cnt;

    modport master (
        output tick,
        output mode_async,
        input  led,
        input  mode_cur,
        input  dbg_phase,
        input  dbg_chase,
        input  dbg_duty,
        input  dbg_dir_down,
        input  dbg_pwm_cnt
    );

    modport slave (
        input  tick,
        input  mode_async,
        output led,
        output mode_cur,
        output dbg_phase,
        output dbg_chase,
        output dbg_duty,
        output dbg_dir_down,
        output dbg_pwm_cnt
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//
// Purpose:
//   LED pattern stage between the ARM GPIO / divider logic and the FPGA LED
//   pins. The pattern mode arrives asynchronously from ARM GPIO and is passed
//   through a SYNC_STAGES flop chain. Patterns: OFF, BLINK, CHASE and
//   BREATHE (PWM fade up/down). Each divider tick advances the pattern.
//
// Parameters:
//   NUM_LED      number of LED outputs (>= 1)
//   PWM_BITS     width of the PWM counter and duty register
//   SYNC_STAGES  synchronizer depth on mode_async (>= 2)
//
// Ports:
//   sclk   system clock (Zynq PL clock)
//   rst    asynchronous reset, active low (0 = reset)
//   bus    led_pattern_ctrl_if.slave: tick, mode_async in; led, mode_cur
//          and debug state out
//
// Build option:
//   LED_ACTIVE_LOW_EN  when defined, led is the bitwise inverse of the
//                      logical pattern and resets to all ones. mode_cur is
//                      unaffected.
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int NUM_LED     = 2,
    parameter int PWM_BITS    = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  sclk,
    input  logic                  rst,
    led_pattern_ctrl_if.slave     bus
);

    // FSM state is the applied mode itself.
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_BLINK   = 2'b01,
        MODE_CHASE   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = '0;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [NUM_LED-1:0]  CHASE_INIT = NUM_LED'(1);

    // XOR mask applied to the logical pattern on its way to the pins; it is
    // also the pin value while in reset.
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [NUM_LED-1:0] LED_XOR = '1;
`else
    localparam logic [NUM_LED-1:0] LED_XOR = '0;
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]          r_sync [SYNC_STAGES];
    mode_e               r_mode_cur;
    logic                r_phase;
    logic [NUM_LED-1:0]  r_chase;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_down;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LED-1:0]  r_led;

    // -----------------------------------------------------------------------
    // Next-state wires
    // -----------------------------------------------------------------------
    logic [1:0]          w_mode_s;
    logic                w_change;
    mode_e               w_mode_nxt;
    logic                w_phase_nxt;
    logic [NUM_LED-1:0]  w_chase_nxt;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_dir_down_nxt;
    logic [PWM_BITS-1:0] w_pwm_cnt_nxt;
    logic [NUM_LED-1:0]  w_pattern;

    assign w_mode_s = r_sync[SYNC_STAGES-1];
    assign w_change = (w_mode_s != r_mode_cur);

    // Rotate left by one with the MSB wrapping into bit 0. Written as a loop
    // so that NUM_LED = 1 degenerates to the identity.
    function automatic logic [NUM_LED-1:0] rotl1(input logic [NUM_LED-1:0] v);
        logic [NUM_LED-1:0] r;
        r = v;
        for (int i = 0; i < NUM_LED; i++) begin
            r[(i + 1) % NUM_LED] = v[i];
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronizer: each mode bit moves independently through the chain.
    // No debounce; a bit that is mid-transition may resolve either way and
    // simply shows up one cycle later.
    // -----------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 2'b00;
            end
        end else begin
            r_sync[0] <= bus.mode_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and pattern datapath.
    // A pending mode change takes priority over a coincident tick: the new
    // mode starts from its initial pattern state and the tick is dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        w_mode_nxt     = r_mode_cur;
        w_phase_nxt    = r_phase;
        w_chase_nxt    = r_chase;
        w_duty_nxt     = r_duty;
        w_dir_down_nxt = r_dir_down;
        w_pwm_cnt_nxt  = DUTY_ZERO;

        if (w_change) begin
            w_mode_nxt     = mode_e'(w_mode_s);
            w_phase_nxt    = 1'b0;
            w_chase_nxt    = CHASE_INIT;
            w_duty_nxt     = DUTY_ZERO;
            w_dir_down_nxt = 1'b0;
        end else begin
            case (r_mode_cur)
                MODE_OFF: begin
                    // Ticks are ignored; everything holds.
                end
                MODE_BLINK: begin
                    if (bus.tick) begin
                        w_phase_nxt = ~r_phase;
                    end
                end
                MODE_CHASE: begin
                    if (bus.tick) begin
                        w_chase_nxt = rotl1(r_chase);
                    end
                end
                MODE_BREATHE: begin
                    // Free-running counter wraps naturally at 2^PWM_BITS.
                    w_pwm_cnt_nxt = r_pwm_cnt + DUTY_ONE;
                    if (bus.tick) begin
                        // Direction flips on the same edge duty lands on an
                        // endpoint, so each endpoint is visited once per
                        // sweep. The saturating guards keep duty in range
                        // even if direction were ever inconsistent.
                        if (r_dir_down) begin
                            if (r_duty == DUTY_ZERO) begin
                                w_dir_down_nxt = 1'b0;
                            end else begin
                                w_duty_nxt = r_duty - DUTY_ONE;
                                if (r_duty == DUTY_ONE) begin
                                    w_dir_down_nxt = 1'b0;
                                end
                            end
                        end else begin
                            if (r_duty == DUTY_MAX) begin
                                w_dir_down_nxt = 1'b1;
                            end else begin
                                w_duty_nxt = r_duty + DUTY_ONE;
                                if (r_duty == (DUTY_MAX - DUTY_ONE)) begin
                                    w_dir_down_nxt = 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Logical LED pattern from the current registered state. It is
    // registered into r_led, so a tick's effect reaches the pins one cycle
    // after the edge that updated the pattern state.
    // -----------------------------------------------------------------------
    always_comb begin
        w_pattern = '0;
        case (r_mode_cur)
            MODE_OFF:     w_pattern = '0;
            MODE_BLINK:   w_pattern = {NUM_LED{r_phase}};
            MODE_CHASE:   w_pattern = r_chase;
            MODE_BREATHE: w_pattern = {NUM_LED{(r_pwm_cnt < r_duty)}};
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_mode_cur <= MODE_OFF;
            r_phase    <= 1'b0;
            r_chase    <= '0;
            r_duty     <= DUTY_ZERO;
            r_dir_down <= 1'b0;
            r_pwm_cnt  <= DUTY_ZERO;
            r_led      <= LED_XOR;
        end else begin
            r_mode_cur <= w_mode_nxt;
            r_phase    <= w_phase_nxt;
            r_chase    <= w_chase_nxt;
            r_duty     <= w_duty_nxt;
            r_dir_down <= w_dir_down_nxt;
            r_pwm_cnt  <= w_pwm_cnt_nxt;
            r_led      <= w_pattern ^ LED_XOR;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.led          = r_led;
    assign bus.mode_cur     = r_mode_cur;
    assign bus.dbg_phase    = r_phase;
    assign bus.dbg_chase    = r_chase;
    assign bus.dbg_duty     = r_duty;
    assign bus.dbg_dir_down = r_dir_down;
    assign bus.dbg_pwm_cnt  = r_pwm_cnt;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Directed bench for led_pattern_ctrl (NUM_LED=2, PWM_BITS=8, SYNC_STAGES=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, well away from the active edge.
// Honors LED_ACTIVE_LOW_EN through exp_led().
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic sclk;
  logic rst;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  led_pattern_ctrl_if #(.NUM_LED(2), .PWM_BITS(8)) bus ();

  led_pattern_ctrl #(
    .NUM_LED    (2),
    .PWM_BITS   (8),
    .SYNC_STAGES(3)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus.slave)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_cmp;
  int n_err;
  logic [1:0] exp_q[$];
  int hi_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_led(input logic [1:0] v);
`ifdef LED_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // One-cycle tick; returns 1 unit after the edge that consumed it.
  task automatic tick_edge();
    bus.tick = 1'b1;
    @(posedge sclk);
    #1;
    bus.tick = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.mode_async = 2'b00;

    // Reset state
    wait_edges(3);
    check("rst_led", bus.led, exp_led(2'b00));
    check("rst_mode", bus.mode_cur, 2'b00);
    check("rst_duty", bus.dbg_duty, 8'd0);

    rst = 1'b1;
    wait_edges(6);
    check("post_rst_mode", bus.mode_cur, 2'b00);
    check("post_rst_led", bus.led, exp_led(2'b00));

    // Sync latency: change lands on edge 4, LED follows on edge 5
    bus.mode_async = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      wait_edges(1);
      check("sync_hold_mode", bus.mode_cur, 2'b00);
    end
    wait_edges(1);
    check("sync_mode_k4", bus.mode_cur, 2'b10);
    check("sync_led_k4", bus.led, exp_led(2'b00));
    wait_edges(1);
    check("chase_first", bus.led, exp_led(2'b01));

    // Chase wrap
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    repeat (3) begin
      tick_edge();
      wait_edges(1);
      check("chase_step", bus.led, exp_led(exp_q.pop_front()));
    end

    // Tick coincident with the mode-change edge to BLINK
    bus.mode_async = 2'b01;
    wait_edges(3);
    bus.tick = 1'b1;
    wait_edges(1);
    bus.tick = 1'b0;
    check("coinc_mode", bus.mode_cur, 2'b01);
    check("coinc_phase", bus.dbg_phase, 1'b0);
    wait_edges(1);
    check("coinc_led", bus.led, exp_led(2'b00));
    wait_edges(3);
    check("coinc_led_hold", bus.led, exp_led(2'b00));

    // Blink: 4 ticks spaced 10 cycles
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    repeat (4) begin
      tick_edge();
      wait_edges(1);
      check("blink_step", bus.led, exp_led(exp_q.pop_front()));
      wait_edges(8);
    end

    // Back to OFF; ticks ignored
    bus.mode_async = 2'b00;
    wait_edges(5);
    check("off_mode", bus.mode_cur, 2'b00);
    check("off_led", bus.led, exp_led(2'b00));
    repeat (2) begin
      tick_edge();
      wait_edges(2);
      check("off_tick_led", bus.led, exp_led(2'b00));
    end

    // Breathe
    bus.mode_async = 2'b11;
    wait_edges(5);
    check("br_mode", bus.mode_cur, 2'b11);
    check("br_led_d0", bus.led, exp_led(2'b00));
    tick_edge();
    check("br_duty1", bus.dbg_duty, 8'd1);
    repeat (254) begin
      wait_edges(1);
      tick_edge();
    end
    check("br_duty_max", bus.dbg_duty, 8'd255);
    check("br_dir_down", bus.dbg_dir_down, 1'b1);
    hi_cnt = 0;
    repeat (256) begin
      wait_edges(1);
      if (bus.led == exp_led(2'b11)) hi_cnt++;
    end
    check("br_high_255", hi_cnt, 32'd255);

    tick_edge();
    check("br_duty254", bus.dbg_duty, 8'd254);
    check("br_dir_still_down", bus.dbg_dir_down, 1'b1);
    repeat (254) begin
      wait_edges(1);
      tick_edge();
    end
    check("br_duty_zero", bus.dbg_duty, 8'd0);
    check("br_dir_up", bus.dbg_dir_down, 1'b0);
    hi_cnt = 0;
    repeat (256) begin
      wait_edges(1);
      if (bus.led != exp_led(2'b00)) hi_cnt++;
    end
    check("br_off_cnt", hi_cnt, 32'd0);

    // Async reset mid-CHASE, between clock edges
    bus.mode_async = 2'b10;
    wait_edges(5);
    check("ar_mode", bus.mode_cur, 2'b10);
    check("ar_led0", bus.led, exp_led(2'b01));
    tick_edge();
    wait_edges(1);
    check("ar_led1", bus.led, exp_led(2'b10));
    #2;
    rst = 1'b0;
    #1;
    check("ar_led_now", bus.led, exp_led(2'b00));
    check("ar_mode_now", bus.mode_cur, 2'b00);
    check("ar_chase_now", bus.dbg_chase, 2'b00);
    bus.mode_async = 2'b00;
    wait_edges(2);
    rst = 1'b1;
    wait_edges(8);
    check("ar_hold_mode", bus.mode_cur, 2'b00);
    check("ar_hold_led", bus.led, exp_led(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- LED pattern stage that consumes the one-cycle divider tick generated in the GPIO/LED path and drives the board LED pins.
- Pattern mode comes from Zynq ARM GPIO pins, which are asynchronous to sclk, and is synchronized internally.
- Supported patterns: off, blink, chase, breathe (PWM).
- Sits between the ARM GPIO/divider logic and the FPGA LED pins.

Parameters:
- NUM_LED, 2, number of LED outputs (>=1)
- PWM_BITS, 8, width of PWM counter and duty register
- SYNC_STAGES, 3, flip-flop stages on mode_async (>=2)

Ports:
- sclk  input  1  system clock from Zynq PL clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- tick  input  1  one-sclk-cycle pulse from upstream divider wrap; pattern step strobe
- mode_async  input  2  pattern select from ARM GPIO pins, asynchronous to sclk
- led  output  NUM_LED  LED drive to FPGA pins, registered
- mode_cur  output  2  currently applied mode, registered

Behaviour:
- Reset (rst=0, async):
  - led=0, mode_cur=0 (OFF).
  - Sync chain, PWM counter, duty, direction, chase vector and blink phase all cleared.
  - Takes effect immediately, including mid-pattern.
- Synchronizer:
  - mode_async passes through SYNC_STAGES flops.
  - mode_s = last stage.
  - Each bit is synchronized independently; no debounce.
- Mode change:
  - When mode_s != mode_cur, mode_cur <= mode_s on the next edge and pattern state is re-initialized in the same edge:
    - blink phase=0
    - chase vector=one-hot bit0
    - duty=0, direction=up
  - A tick coincident with a mode change is ignored; the change wins.
  - Latency: mode_async edge to mode_cur update = SYNC_STAGES+1 cycles.
- FSM states = mode_cur:
  - OFF (00): led=0 constantly; tick ignored.
  - BLINK (01):
    - Each tick toggles blink phase.
    - led = all ones when phase=1, else all zeros.
  - CHASE (10):
    - led = chase vector.
    - Each tick rotates left by 1; MSB wraps to bit0.
    - NUM_LED=1: vector stays 1.
  - BREATHE (11):
    - pwm_cnt (PWM_BITS) free-runs +1 every sclk while in BREATHE and wraps at 2^PWM_BITS-1 -> 0; it is held at 0 in other modes.
    - All LEDs = (pwm_cnt < duty).
    - Each tick: duty +1 if direction=up, -1 if down.
    - When duty reaches 2^PWM_BITS-1, direction flips to down on that same edge; when duty reaches 0, direction flips to up on that same edge.
    - Duty never over- or underflows; endpoints are visited once per cycle.
    - duty=0 -> LEDs fully off; duty=max -> on (max)/(2^PWM_BITS) of the time.
- led timing:
  - Registered; reflects state updated by a tick one sclk after that tick.
  - In BREATHE, led compares registered pwm_cnt and duty, giving 1 cycle of latency.
- tick held high multiple cycles: each high cycle counts as a step (upstream guarantees a single pulse; not a checked error).
- Uninitialized or X mode_async: no requirement beyond reset state.

Optional Feature:
- LED_ACTIVE_LOW_EN
- Defined:
  - led output is the bitwise inverse of the logical pattern.
  - Reset value of led = all ones.
  - mode_cur is unaffected.
- Undefined: led is active-high as described above; reset value all zeros.

Test Plan:
- Reset/async:
  - Assert rst=0 mid-CHASE between clock edges -> led=0 and mode_cur=0 immediately, without waiting for an edge.
  - Release rst -> holds OFF.
- Mode sync latency:
  - mode_async 00->10 at cycle 0 with SYNC_STAGES=3 -> mode_cur=10 at cycle 4 and led=2'b01 one cycle later.
  - No change before cycle 4.
- Chase wrap (NUM_LED=2):
  - In CHASE, apply 3 ticks -> led 01->10->01->10.
  - A tick on the same cycle as a mode change to BLINK -> led=00, phase=0; the tick has no effect.
- Blink:
  - Mode 01, 4 ticks spaced 10 cycles -> led 11,00,11,00.
  - Mode 00 -> led=00 and further ticks ignored.
- Breathe endpoints (PWM_BITS=8):
  - 255 ticks -> duty=255 and direction=down; over 256 cycles led high for exactly 255.
  - Next tick -> duty=254.
  - Continue 254 ticks -> duty=0, led constant 0, direction=up.
- LED_ACTIVE_LOW_EN defined: reset -> led=2'b11; CHASE first state -> led=2'b10.
